// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS run controller:
// FSM state encodings and the command-priority decoder.
package mips_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;
    localparam logic [2:0] ST_STEP  = 3'd5;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_HALT = 3'd2,
        CMD_STEP = 3'd3,
        CMD_RUN  = 3'd4
    } cmd_e;

    // Overlapping level commands collapse to the highest-priority one.
    function automatic cmd_e decode_cmd(
        input logic load,
        input logic halt,
        input logic step,
        input logic run
    );
        if (load)      return CMD_LOAD;
        else if (halt) return CMD_HALT;
        else if (step) return CMD_STEP;
        else if (run)  return CMD_RUN;
        else           return CMD_NONE;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_byte_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words and
// emits a registered one-cycle pulse per completed word.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 2'd0;
            shift      <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else if (clear) begin
            cnt        <= 2'd0;
            shift      <= 24'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_en) begin
                cnt   <= cnt + 2'd1;
                shift <= {shift[15:0], byte_data};
                if (cnt == 2'd3) begin
                    word_valid <= 1'b1;
                    word       <= {shift, byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: loads a program into ROM from a byte stream, then
// gates the processor clock enable for run / halt / step / breakpoint.
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter  int MEMORY_DEPTH = 32,
    localparam int AW           = $clog2(MEMORY_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start_i,
    input  logic [15:0]   load_words_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic          run_i,
    input  logic          halt_i,
    input  logic          step_i,
    input  logic          bp_en_i,
    input  logic [31:0]   bp_addr_i,
    input  logic [31:0]   pc_i,
    output logic          cpu_reset_n_o,
    output logic          cpu_clk_en_o,
    output logic          rom_we_o,
    output logic [AW-1:0] rom_addr_o,
    output logic [31:0]   rom_wdata_o,
    output logic [2:0]    state_o,
    output logic          load_err_o,
    output logic [31:0]   cycle_cnt_o
);

    localparam logic [16:0] DEPTH17 = 17'(MEMORY_DEPTH);

    logic [2:0]  state;
    logic [2:0]  next_state;
    cmd_e        cmd;
    logic        load_go;
    logic        load_bad;
    logic        bp_skip;
    logic        bp_hit;
    logic [15:0] words_left;
    logic        last_write;

    assign cmd        = decode_cmd(load_start_i, halt_i, step_i, run_i);
    assign load_go    = (cmd == CMD_LOAD);
    assign load_bad   = {1'b0, load_words_i} > DEPTH17;
    assign bp_hit     = bp_en_i && (pc_i == bp_addr_i) && !bp_skip;
    assign last_write = rom_we_o && (words_left == 16'd1);

    assign state_o       = state;
    assign byte_ready_o  = (state == ST_LOAD);
    assign cpu_reset_n_o = (state == ST_RUN) || (state == ST_HALT) ||
                           (state == ST_STEP);

    // A halt or breakpoint stops the processor in the very cycle it is seen.
    assign cpu_clk_en_o = (state == ST_STEP) ||
                          ((state == ST_RUN) && (cmd != CMD_LOAD) &&
                           (cmd != CMD_HALT) && !bp_hit);

    always_comb begin
        next_state = state;
        if (load_go) begin
            if (load_bad)
                next_state = ST_IDLE;
            else if (load_words_i == 16'd0)
                next_state = ST_READY;
            else
                next_state = ST_LOAD;
        end else begin
            unique case (state)
                ST_IDLE: next_state = ST_IDLE;
                ST_LOAD: begin
                    if (last_write) next_state = ST_READY;
                end
                ST_READY: begin
                    if (cmd == CMD_STEP)     next_state = ST_STEP;
                    else if (cmd == CMD_RUN) next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (cmd == CMD_HALT || bp_hit) next_state = ST_HALT;
                end
                ST_HALT: begin
                    if (cmd == CMD_STEP)     next_state = ST_STEP;
                    else if (cmd == CMD_RUN) next_state = ST_RUN;
                end
                ST_STEP: next_state = ST_HALT;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            load_err_o  <= 1'b0;
            rom_addr_o  <= '0;
            words_left  <= 16'd0;
            bp_skip     <= 1'b0;
            cycle_cnt_o <= 32'd0;
        end else begin
            state <= next_state;

            if (load_go) begin
                load_err_o <= load_bad;
                rom_addr_o <= '0;
                words_left <= load_words_i;
            end else if (rom_we_o) begin
                rom_addr_o <= rom_addr_o + AW'(1);
                words_left <= words_left - 16'd1;
            end

            // Resuming from HALT must execute the instruction at the breakpoint.
            if (state == ST_HALT && next_state == ST_RUN)
                bp_skip <= 1'b1;
            else if (state == ST_RUN)
                bp_skip <= 1'b0;

            if (load_go && next_state == ST_LOAD)
                cycle_cnt_o <= 32'd0;
            else if (cpu_clk_en_o)
                cycle_cnt_o <= cycle_cnt_o + 32'd1;
        end
    end

    logic [31:0] asm_word;
    logic        asm_valid;

    byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_go),
        .byte_en    (byte_valid_i && byte_ready_o),
        .byte_data  (byte_data_i),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    assign rom_we_o    = asm_valid;
    assign rom_wdata_o = asm_word;

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 Parameter: MEMORY_DEPTH, 32, program memory depth in 32-bit words; AW = clog2(MEMORY_DEPTH).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 load_start_i  in  1  one-cycle pulse; starts program load.
REQ-005 load_words_i  in  16  number of words to load; sampled on load_start_i.
REQ-006 byte_valid_i / byte_data_i  in  1 / 8  loader byte stream; byte accepted when byte_valid_i && byte_ready_o.
REQ-007 byte_ready_o  out  1  high only in LOAD.
REQ-008 run_i, halt_i, step_i  in  1 each  level commands, sampled every cycle.
REQ-009 bp_en_i / bp_addr_i  in  1 / 32  breakpoint enable and byte address.
REQ-010 pc_i  in  32  processor PC value.
REQ-011 cpu_reset_n_o  out  1  active-low reset to processor PC and register file.
REQ-012 cpu_clk_en_o  out  1  processor state-update enable.
REQ-013 rom_we_o / rom_addr_o / rom_wdata_o  out  1 / AW / 32  program-memory write port.
REQ-014 state_o  out  3  encoded FSM state; load_err_o  out  1; cycle_cnt_o  out  32.

Function
REQ-015 States: IDLE=0, LOAD=1, READY=2, RUN=3, HALT=4, STEP=5.
REQ-016 Command priority in any state: load_start_i > halt_i > step_i > run_i.
REQ-017 IDLE/READY/LOAD: cpu_reset_n_o=0, cpu_clk_en_o=0; RUN/HALT/STEP: cpu_reset_n_o=1.
REQ-018 IDLE -> LOAD on load_start_i; load_words_i==0 -> READY directly; load_words_i>MEMORY_DEPTH -> IDLE, load_err_o=1.
REQ-019 LOAD: bytes assembled big-endian (first byte -> bits 31:24); 4th byte -> rom_we_o=1 for exactly one cycle next cycle, rom_addr_o = word index from 0, incremented after each write.
REQ-020 LOAD -> READY the cycle after the write of word load_words_i-1; load_start_i in LOAD restarts at word 0, partial word discarded.
REQ-021 READY -> RUN on run_i; READY -> STEP on step_i.
REQ-022 RUN: cpu_clk_en_o combinational = 1 unless breakpoint hit (bp_en_i && pc_i==bp_addr_i && !bp_skip); hit -> HALT, instruction at bp_addr_i not executed.
REQ-023 RUN -> HALT on halt_i; cpu_clk_en_o=0 in that same cycle.
REQ-024 HALT: cpu_clk_en_o=0; -> RUN on run_i, -> STEP on step_i, -> LOAD on load_start_i (reasserts cpu reset).
REQ-025 STEP: cpu_clk_en_o=1 for exactly one cycle, breakpoint ignored, then HALT.
REQ-026 bp_skip set on entry to RUN from HALT, cleared after first RUN cycle, so resume at breakpoint PC executes it.
REQ-027 cycle_cnt_o increments each cycle cpu_clk_en_o=1, clears on entry to LOAD, wraps at 2^32-1 -> 0.
REQ-028 load_err_o clears on next accepted load_start_i.

Reset
REQ-029 reset low: state IDLE, cpu_reset_n_o=0, cpu_clk_en_o=0, byte_ready_o=0, rom_we_o=0, rom_addr_o=0, rom_wdata_o=0, load_err_o=0, cycle_cnt_o=0, byte counter 0, bp_skip=0.
REQ-030 reset mid-LOAD abandons the load, no further rom_we_o pulse.

Structure
REQ-031 State encodings and command-priority constants in shared package mips_ctrl_pkg.
REQ-032 One sub-module: byte_word_assembler (byte count, shift register, word-valid pulse).

Verification
REQ-033 Load 3 words bytes 00 11 22 33, 44 55 66 77, 88 99 AA BB -> rom writes addr 0..2 data 00112233/44556677/8899AABB, then READY.
REQ-034 load_words_i=40 with MEMORY_DEPTH=32 -> IDLE, load_err_o=1, no rom_we_o.
REQ-035 RUN with bp_addr_i=0x0040000C, pc stepping by 4 from 0x00400000 -> 3 enabled cycles, HALT, cycle_cnt_o=3; run_i -> executes 0x0040000C.
REQ-036 HALT, step_i held 1 cycle -> cpu_clk_en_o high exactly 1 cycle, back to HALT.
REQ-037 halt_i and run_i together in RUN -> HALT (priority).
REQ-038 reset low after 2 bytes of LOAD -> all outputs at reset values, IDLE.
